beam_sweep_scheduler: RTL and testbench

BEAM_SWEEP_SCHEDULER -- requirements
Module: beam_sweep_scheduler

---
 rtl/sonic_pkg.sv | 24 ++
 rtl/echo_min_tracker.sv | 84 ++++++++
 rtl/beam_sweep_scheduler.sv | 164 ++++++++++++++++
 tb/tb_beam_sweep_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// Shared types and constants for the sonar beam sweep scheduler.
package sonic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StListen,
        StSettle
    } state_e;

    localparam logic [15:0] NO_ECHO = 16'hFFFF;

    localparam int ANGLE_MIN_DEF  = -30;
    localparam int ANGLE_MAX_DEF  = 30;
    localparam int ANGLE_STEP_DEF = 10;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/echo_min_tracker.sv
// Captures the first echo of each dwell and keeps the sweep-wide minimum range and its angle.
module echo_min_tracker
    import sonic_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clear_in,
    input  logic               capture_in,
    input  logic [15:0]        range_in,
    input  logic               listen_end_in,
    input  logic signed [7:0]  angle_in,
    input  logic               commit_in,
    output logic [15:0]        best_range_out,
    output logic signed [7:0]  best_angle_out,
    output logic               hit_out
);

    logic              dwell_got_q, dwell_got_d;
    logic [15:0]       dwell_range_q, dwell_range_d;
    logic [15:0]       min_q, min_d;
    logic signed [7:0] min_ang_q, min_ang_d;
    logic [15:0]       best_range_q, best_range_d;
    logic signed [7:0] best_ang_q, best_ang_d;
    logic              hit_q, hit_d;
    logic [15:0]       dwell_range;

    always_comb begin
        // A strobe on the final LISTEN cycle must still count for this dwell.
        dwell_range   = dwell_got_q ? dwell_range_q : (capture_in ? range_in : NO_ECHO);
        dwell_got_d   = dwell_got_q;
        dwell_range_d = dwell_range_q;
        if (capture_in && !dwell_got_q) begin
            dwell_got_d   = 1'b1;
            dwell_range_d = range_in;
        end
        if (listen_end_in) begin
            dwell_got_d = 1'b0;
        end

        min_d     = min_q;
        min_ang_d = min_ang_q;
        if (clear_in) begin
            min_d     = NO_ECHO;
            min_ang_d = '0;
        end else if (listen_end_in && (dwell_range < min_q)) begin
            min_d     = dwell_range;
            min_ang_d = angle_in;
        end

        best_range_d = best_range_q;
        best_ang_d   = best_ang_q;
        hit_d        = hit_q;
        if (commit_in) begin
            best_range_d = min_q;
            best_ang_d   = min_ang_q;
            hit_d        = (min_q != NO_ECHO);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dwell_got_q   <= 1'b0;
            dwell_range_q <= NO_ECHO;
            min_q         <= NO_ECHO;
            min_ang_q     <= '0;
            best_range_q  <= NO_ECHO;
            best_ang_q    <= '0;
            hit_q         <= 1'b0;
        end else begin
            dwell_got_q   <= dwell_got_d;
            dwell_range_q <= dwell_range_d;
            min_q         <= min_d;
            min_ang_q     <= min_ang_d;
            best_range_q  <= best_range_d;
            best_ang_q    <= best_ang_d;
            hit_q         <= hit_d;
        end
    end

    assign best_range_out = best_range_q;
    assign best_angle_out = best_ang_q;
    assign hit_out        = hit_q;

endmodule

// File: rtl/beam_sweep_scheduler.sv
// Steps the sonar beam across the sweep, sequencing burst/listen/settle dwells at each angle.
module beam_sweep_scheduler
    import sonic_pkg::*;
#(
    parameter int unsigned BURST_CYCLES  = 524288,
    parameter int unsigned LISTEN_CYCLES = 16252928,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int          ANGLE_MIN     = ANGLE_MIN_DEF,
    parameter int          ANGLE_MAX     = ANGLE_MAX_DEF,
    parameter int          ANGLE_STEP    = ANGLE_STEP_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              tof_valid_in,
    input  logic [15:0]       range_in,
    output logic signed [7:0] beam_angle_out,
    output logic              burst_start_out,
    output logic              burst_out,
    output logic              listen_out,
    output logic              sweep_done_out,
    output logic [15:0]       best_range_out,
    output logic signed [7:0] best_angle_out,
    output logic              hit_out
);

    localparam int unsigned MaxDur = max3(BURST_CYCLES, LISTEN_CYCLES, SETTLE_CYCLES);
    localparam int unsigned CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;

    localparam logic [CntW-1:0] BurstLast  = CntW'(BURST_CYCLES - 1);
    localparam logic [CntW-1:0] ListenLast = CntW'(LISTEN_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    localparam logic signed [7:0] AngleMin  = 8'(ANGLE_MIN);
    localparam logic signed [7:0] AngleMax  = 8'(ANGLE_MAX);
    localparam logic signed [7:0] AngleStep = 8'(ANGLE_STEP);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic signed [7:0] angle_q, angle_d;
    logic              burst_start_q, burst_start_d;
    logic              burst_q, burst_d;
    logic              listen_q, listen_d;
    logic              done_q, done_d;
    logic              state_last;
    logic              clear_min;
    logic              sweep_end;
    logic              listen_end;
    logic              capture;

    always_comb begin
        unique case (state_q)
            StBurst:  state_last = (cnt_q == BurstLast);
            StListen: state_last = (cnt_q == ListenLast);
            StSettle: state_last = (cnt_q == SettleLast);
            default:  state_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        angle_d   = angle_q;
        clear_min = 1'b0;
        sweep_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable_in) begin
                    state_d   = StBurst;
                    angle_d   = AngleMin;
                    clear_min = 1'b1;
                end
            end
            StBurst: begin
                if (state_last) begin
                    state_d = StListen;
                    cnt_d   = '0;
                end
            end
            StListen: begin
                if (state_last) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (state_last) begin
                    cnt_d = '0;
                    if (angle_q == AngleMax) begin
                        sweep_end = 1'b1;
                        if (enable_in) begin
                            state_d   = StBurst;
                            angle_d   = AngleMin;
                            clear_min = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (enable_in) begin
                        state_d = StBurst;
                        angle_d = angle_q + AngleStep;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Level outputs are registered from the next state so they align with it exactly.
        burst_start_d = (state_d == StBurst) && (state_q != StBurst);
        burst_d       = (state_d == StBurst);
        listen_d      = (state_d == StListen);
        done_d        = sweep_end;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            angle_q       <= '0;
            burst_start_q <= 1'b0;
            burst_q       <= 1'b0;
            listen_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            angle_q       <= angle_d;
            burst_start_q <= burst_start_d;
            burst_q       <= burst_d;
            listen_q      <= listen_d;
            done_q        <= done_d;
        end
    end

    assign capture    = tof_valid_in && (state_q == StListen);
    assign listen_end = (state_q == StListen) && state_last;

    echo_min_tracker u_tracker (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clear_in      (clear_min),
        .capture_in    (capture),
        .range_in      (range_in),
        .listen_end_in (listen_end),
        .angle_in      (angle_q),
        .commit_in     (sweep_end),
        .best_range_out(best_range_out),
        .best_angle_out(best_angle_out),
        .hit_out       (hit_out)
    );

    assign beam_angle_out  = angle_q;
    assign burst_start_out = burst_start_q;
    assign burst_out       = burst_q;
    assign listen_out      = listen_q;
    assign sweep_done_out  = done_q;

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Scoreboard bench: stimulus queues expected dwell angles and sweep results, a monitor checks them.
module tb_beam_sweep_scheduler;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              tof_valid;
    logic [15:0]       range;
    logic signed [7:0] beam_angle;
    logic              burst_start;
    logic              burst;
    logic              listen;
    logic              sweep_done;
    logic [15:0]       best_range;
    logic signed [7:0] best_angle;
    logic              hit;

    beam_sweep_scheduler #(
        .BURST_CYCLES (4),
        .LISTEN_CYCLES(20),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .enable_in      (enable),
        .tof_valid_in   (tof_valid),
        .range_in       (range),
        .beam_angle_out (beam_angle),
        .burst_start_out(burst_start),
        .burst_out      (burst),
        .listen_out     (listen),
        .sweep_done_out (sweep_done),
        .best_range_out (best_range),
        .best_angle_out (best_angle),
        .hit_out        (hit)
    );

    typedef struct {
        int rng;
        int ang;
        int hit;
    } res_t;

    res_t res_q[$];
    int   ang_q[$];
    int   total = 0;
    int   bad   = 0;
    int   rel   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected results whenever the DUT presents them.
    int   mcyc = 0;
    int   start_cyc = 0;
    bit   start_ok = 0;
    int   cur_ang = 0;
    int   b_run = 0;
    int   l_run = 0;
    res_t e;

    always @(negedge clk) begin
        mcyc++;
        if (rst === 1'b1) begin
            b_run    = 0;
            l_run    = 0;
            start_ok = 0;
        end else begin
            if (sweep_done === 1'b1) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_sweep_done", 1, 0);
                end else begin
                    e = res_q.pop_front();
                    chk("best_range", best_range, e.rng);
                    chk("best_angle", best_angle, e.ang);
                    chk("hit", hit, e.hit);
                end
                if (start_ok) chk("done_cycle", mcyc - start_cyc, 182);
            end
            if (burst_start === 1'b1) begin
                if (ang_q.size() == 0) begin
                    chk("unexpected_dwell", 1, 0);
                end else begin
                    cur_ang = ang_q.pop_front();
                    chk("dwell_angle", beam_angle, cur_ang);
                end
                if (beam_angle == -30) begin
                    start_cyc = mcyc;
                    start_ok  = 1;
                end
            end
            if ((burst === 1'b1) || (listen === 1'b1)) chk("angle_stable", beam_angle, cur_ang);
            if (burst === 1'b1) b_run++;
            else if (b_run != 0) begin
                chk("burst_len", b_run, 4);
                b_run = 0;
            end
            if (listen === 1'b1) l_run++;
            else if (l_run != 0) begin
                chk("listen_len", l_run, 20);
                l_run = 0;
            end
        end
    end

    task automatic goto(input int r);
        while (rel < r) begin
            @(posedge clk);
            #1;
            rel++;
        end
    endtask

    task automatic pulse(input int at, input int r);
        goto(at);
        tof_valid = 1'b1;
        range     = 16'(r);
        goto(at + 1);
        tof_valid = 1'b0;
    endtask

    task automatic wait_burst_start();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((burst_start !== 1'b1) && (n < 300));
        if (burst_start !== 1'b1) chk("burst_start_timeout", 0, 1);
        rel = 0;
    endtask

    task automatic push_sweep();
        for (int a = -30; a <= 30; a += 10) ang_q.push_back(a);
    endtask

    task automatic push_res(input int r, input int a, input int h);
        res_t x;
        x.rng = r;
        x.ang = a;
        x.hit = h;
        res_q.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_angle"}, beam_angle, 0);
        chk({tag, "_burst_start"}, burst_start, 0);
        chk({tag, "_burst"}, burst, 0);
        chk({tag, "_listen"}, listen, 0);
        chk({tag, "_done"}, sweep_done, 0);
        chk({tag, "_best_range"}, best_range, 16'hFFFF);
        chk({tag, "_best_angle"}, best_angle, 0);
        chk({tag, "_hit"}, hit, 0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        tof_valid = 1'b0;
        range     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;

        // Five full sweeps then two dwells of a sweep abandoned by enable dropping.
        for (int s = 0; s < 5; s++) push_sweep();
        ang_q.push_back(-30);
        ang_q.push_back(-20);
        push_res(16'hFFFF, 0, 0);
        push_res(300, 20, 1);
        push_res(800, 0, 1);
        push_res(900, -20, 1);
        push_res(700, 10, 1);

        enable = 1'b1;
        wait_burst_start();

        // Equal 300 echoes: the earlier angle wins.
        pulse(244, 500);
        pulse(322, 300);
        pulse(348, 300);
        // Strobes in BURST and SETTLE are ignored.
        pulse(365, 10);
        pulse(414, 10);
        pulse(452, 800);
        // Only the first strobe per LISTEN counts; edges outside LISTEN ignored.
        pulse(577, 900);
        pulse(580, 100);
        pulse(622, 5);
        pulse(627, 10);
        // Strobe on the final LISTEN cycle is accepted.
        pulse(855, 700);
        // Echo in an abandoned sweep never reaches the results.
        pulse(924, 200);
        goto(946);
        enable = 1'b0;
        goto(1000);
        chk("idle_burst", burst, 0);
        chk("idle_listen", listen, 0);
        chk("held_best_range", best_range, 700);
        chk("held_best_angle", best_angle, 10);
        chk("held_hit", hit, 1);
        chk("partial_angles_consumed", ang_q.size(), 0);

        // Reset in LISTEN wins over enable and a strobe in the same cycle.
        ang_q.push_back(-30);
        enable = 1'b1;
        wait_burst_start();
        goto(10);
        rst       = 1'b1;
        tof_valid = 1'b1;
        range     = 16'd5;
        goto(11);
        rst       = 1'b0;
        tof_valid = 1'b0;
        chk_reset_outputs("rst_listen");
        ang_q.push_back(-30);
        wait_burst_start();
        goto(5);
        enable = 1'b0;
        goto(40);
        chk("post_rst_burst", burst, 0);
        chk("post_rst_listen", listen, 0);
        chk("post_rst_best_range", best_range, 16'hFFFF);
        chk("post_rst_hit", hit, 0);

        chk("angle_queue_empty", ang_q.size(), 0);
        chk("result_queue_empty", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
